// File: rtl/s_mem_scheduler.sv
// Key-schedule/decrypt phase sequencer and single-port S-memory arbiter; 1-cycle registered memory port.
// Optional host/debug port in IDLE/DONE is compiled only with S_MEM_HOST_PORT_EN.
module s_mem_scheduler (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       start_over,
   output logic       init_start,
   output logic       shuf_start,
   output logic       dec_start,
   input  logic       init_done,
   input  logic       shuf_done,
   input  logic       dec_done,
   input  logic [7:0] init_addr,
   input  logic [7:0] shuf_addr,
   input  logic [7:0] dec_addr,
   input  logic [7:0] init_data,
   input  logic [7:0] shuf_data,
   input  logic [7:0] dec_data,
   input  logic       init_wren,
   input  logic       shuf_wren,
   input  logic       dec_wren,
   input  logic       host_req,
   input  logic [7:0] host_addr,
   input  logic [7:0] host_data,
   input  logic       host_wren,
   output logic       host_gnt,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_wren,
   output logic [2:0] phase,
   output logic       busy,
   output logic       all_done
);

   typedef enum logic [2:0] {IDLE = 3'd0, INIT = 3'd1, SHUF = 3'd2, DEC = 3'd3, DONE = 3'd4} state_t;

   state_t     state, nxt;
   logic       pulse, change;
   logic [7:0] sel_addr, sel_data;
   logic       sel_wren;

   // Done levels are still stale from the previous run while the start pulse is out.
   assign pulse = init_start | shuf_start | dec_start;

   always_comb begin
      nxt = state;
      if (start_over) begin
         nxt = INIT;
      end else begin
         case (state)
            IDLE:    if (start) nxt = INIT;
            INIT:    if (!pulse && init_done) nxt = SHUF;
            SHUF:    if (!pulse && shuf_done) nxt = DEC;
            DEC:     if (!pulse && dec_done) nxt = DONE;
            DONE:    if (start) nxt = INIT;
            default: nxt = IDLE;
         endcase
      end
   end

   assign change = start_over || (nxt != state);

   always_comb begin
      sel_addr = init_addr;
      sel_data = init_data;
      sel_wren = init_wren;
      case (state)
         SHUF: begin
            sel_addr = shuf_addr;
            sel_data = shuf_data;
            sel_wren = shuf_wren;
         end
         DEC: begin
            sel_addr = dec_addr;
            sel_data = dec_data;
            sel_wren = dec_wren;
         end
         default: ;
      endcase
   end

`ifndef S_MEM_HOST_PORT_EN
   logic host_unused;
   assign host_unused = ^{host_req, host_addr, host_data, host_wren};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         init_start <= 1'b0;
         shuf_start <= 1'b0;
         dec_start  <= 1'b0;
         busy       <= 1'b0;
         all_done   <= 1'b0;
         host_gnt   <= 1'b0;
         mem_addr   <= 8'h00;
         mem_data   <= 8'h00;
         mem_wren   <= 1'b0;
      end else begin
         state      <= nxt;
         init_start <= change && (nxt == INIT);
         shuf_start <= change && (nxt == SHUF);
         dec_start  <= change && (nxt == DEC);
         busy       <= (nxt == INIT) || (nxt == SHUF) || (nxt == DEC);
         all_done   <= (nxt == DONE);
         if (state == INIT || state == SHUF || state == DEC) begin
            host_gnt <= 1'b0;
            mem_addr <= sel_addr;
            mem_data <= sel_data;
            mem_wren <= sel_wren && !pulse && !change;
         end else begin
`ifdef S_MEM_HOST_PORT_EN
            // A host access that collides with a sequence start is refused outright.
            if (host_req && !change) begin
               host_gnt <= 1'b1;
               mem_addr <= host_addr;
               mem_data <= host_data;
               mem_wren <= host_wren;
            end else begin
               host_gnt <= 1'b0;
               mem_wren <= 1'b0;
            end
`else
            host_gnt <= 1'b0;
            mem_wren <= 1'b0;
`endif
         end
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_s_mem_scheduler.sv
// Self-checking bench for s_mem_scheduler: phase sequencing, pulse/done masking, memory mux, host port, reset.
module tb_s_mem_scheduler;

   logic       clk = 1'b0;
   logic       reset, start, start_over;
   logic       init_start, shuf_start, dec_start;
   logic       init_done, shuf_done, dec_done;
   logic [7:0] init_addr, shuf_addr, dec_addr, init_data, shuf_data, dec_data;
   logic       init_wren, shuf_wren, dec_wren;
   logic       host_req, host_wren, host_gnt;
   logic [7:0] host_addr, host_data;
   logic [7:0] mem_addr, mem_data;
   logic       mem_wren;
   logic [2:0] phase;
   logic       busy, all_done;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic       wren;
   } mem_t;

   mem_t exp_q[$];
   mem_t e;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   s_mem_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .start_over(start_over),
      .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
      .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done),
      .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
      .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
      .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
      .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_wren(host_wren),
      .host_gnt(host_gnt), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
      .phase(phase), .busy(busy), .all_done(all_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      reset = 0; start = 0; start_over = 0;
      init_done = 0; shuf_done = 0; dec_done = 0;
      init_addr = 0; shuf_addr = 0; dec_addr = 0;
      init_data = 0; shuf_data = 0; dec_data = 0;
      init_wren = 0; shuf_wren = 0; dec_wren = 0;
      host_req = 0; host_addr = 0; host_data = 0; host_wren = 0;
   endtask

   // From a pulse cycle: hold done through the masked cycle and the accepting edge.
   task automatic finish_init();
      init_done = 1; tick(); tick(); init_done = 0;
   endtask
   task automatic finish_shuf();
      shuf_done = 1; tick(); tick(); shuf_done = 0;
   endtask
   task automatic finish_dec();
      dec_done = 1; tick(); tick(); dec_done = 0;
   endtask

   task automatic do_reset_and_start();
      clear_inputs();
      reset = 1; tick(); reset = 0;
      start = 1; tick(); start = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1; start = 1; tick(); tick(); start = 0; reset = 0;
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
      total++; if ({busy, all_done, host_gnt} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, all_done, host_gnt}); end
      total++; if ({init_start, shuf_start, dec_start} !== 3'b000) begin bad++; $display("FAIL reset_starts got=%b want=000", {init_start, shuf_start, dec_start}); end
      total++; if ({mem_addr, mem_data, mem_wren} !== 17'd0) begin bad++; $display("FAIL reset_mem got=%h/%h/%b want=00/00/0", mem_addr, mem_data, mem_wren); end
   endtask

   task automatic test_start_pulse();
      start = 1; tick(); start = 0;
      total++; if ({phase, init_start, busy} !== {3'd1, 1'b1, 1'b1}) begin bad++; $display("FAIL start_pulse got=%0d/%b/%b want=1/1/1", phase, init_start, busy); end
      init_done = 1;  // stale level during the pulse cycle
      tick();
      total++; if ({phase, init_start} !== {3'd1, 1'b0}) begin bad++; $display("FAIL done_masked got=%0d/%b want=1/0", phase, init_start); end
      tick();
      total++; if ({phase, shuf_start} !== {3'd2, 1'b1}) begin bad++; $display("FAIL init_to_shuf got=%0d/%b want=2/1", phase, shuf_start); end
      init_done = 0;
   endtask

   task automatic test_full_run();
      // Foreign done levels must not move the SHUF phase.
      tick();
      init_done = 1; dec_done = 1; tick(); tick(); init_done = 0; dec_done = 0;
      total++; if (phase !== 3'd2) begin bad++; $display("FAIL foreign_done got=%0d want=2", phase); end
      shuf_done = 1; tick();
      total++; if ({phase, dec_start} !== {3'd3, 1'b1}) begin bad++; $display("FAIL shuf_to_dec got=%0d/%b want=3/1", phase, dec_start); end
      shuf_done = 0;
      finish_dec();
      total++; if ({phase, all_done, busy} !== {3'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL dec_to_done got=%0d/%b/%b want=4/1/0", phase, all_done, busy); end
      start = 1; tick(); start = 0;
      total++; if ({phase, init_start, all_done} !== {3'd1, 1'b1, 1'b0}) begin bad++; $display("FAIL done_restart got=%0d/%b/%b want=1/1/0", phase, init_start, all_done); end
   endtask

   task automatic test_start_over();
      finish_init();
      tick();
      shuf_done = 1; start_over = 1; tick(); shuf_done = 0; start_over = 0;
      total++; if ({phase, init_start, dec_start} !== {3'd1, 1'b1, 1'b0}) begin bad++; $display("FAIL start_over_shuf got=%0d/%b/%b want=1/1/0", phase, init_start, dec_start); end
      tick();
      start_over = 1; tick(); start_over = 0;
      total++; if ({phase, init_start} !== {3'd1, 1'b1}) begin bad++; $display("FAIL start_over_init got=%0d/%b want=1/1", phase, init_start); end
      tick();
   endtask

   task automatic test_mem_path();
      // In INIT, past the pulse.
      init_addr = 8'h05; init_data = 8'h05; init_wren = 1;
      shuf_addr = 8'h77; shuf_data = 8'h33; shuf_wren = 1;
      exp_q.push_back('{addr: 8'h05, data: 8'h05, wren: 1'b1});
      tick();
      e = exp_q.pop_front();
      total++; if ({mem_addr, mem_data, mem_wren} !== e) begin bad++; $display("FAIL mem_init got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_data, mem_wren, e.addr, e.data, e.wren); end
      for (int i = 0; i < 6; i++) begin
         init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
         dec_addr = 8'($urandom); dec_wren = 1;
         exp_q.push_back('{addr: init_addr, data: init_data, wren: init_wren});
         tick();
         e = exp_q.pop_front();
         total++; if ({mem_addr, mem_data, mem_wren} !== e) begin bad++; $display("FAIL mem_rand%0d got=%h/%h/%b want=%h/%h/%b", i, mem_addr, mem_data, mem_wren, e.addr, e.data, e.wren); end
      end
      init_addr = 8'hFF; init_data = 8'h11; init_wren = 1; start_over = 1;
      exp_q.push_back('{addr: 8'hFF, data: 8'h11, wren: 1'b0});
      tick(); start_over = 0;
      e = exp_q.pop_front();
      total++; if ({mem_addr, mem_data, mem_wren} !== e) begin bad++; $display("FAIL mem_change got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_data, mem_wren, e.addr, e.data, e.wren); end
      init_addr = 8'h00; init_data = 8'h22;
      exp_q.push_back('{addr: 8'h00, data: 8'h22, wren: 1'b0});
      tick();
      e = exp_q.pop_front();
      total++; if ({mem_addr, mem_data, mem_wren} !== e) begin bad++; $display("FAIL mem_pulse got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_data, mem_wren, e.addr, e.data, e.wren); end
      exp_q.push_back('{addr: 8'h00, data: 8'h22, wren: 1'b1});
      tick();
      e = exp_q.pop_front();
      total++; if ({mem_addr, mem_data, mem_wren} !== e) begin bad++; $display("FAIL mem_after got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_data, mem_wren, e.addr, e.data, e.wren); end
      clear_inputs();
   endtask

   task automatic test_host();
      do_reset_and_start();
      finish_init(); finish_shuf(); finish_dec();
      tick();
      host_req = 1; host_addr = 8'hFF; host_data = 8'hA5; host_wren = 1;
`ifdef S_MEM_HOST_PORT_EN
      exp_q.push_back('{addr: 8'hFF, data: 8'hA5, wren: 1'b1});
`else
      exp_q.push_back('{addr: mem_addr, data: mem_data, wren: 1'b0});
`endif
      tick();
      e = exp_q.pop_front();
`ifdef S_MEM_HOST_PORT_EN
      total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL host_gnt_done got=%b want=1", host_gnt); end
`else
      total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL host_gnt_off got=%b want=0", host_gnt); end
`endif
      total++; if ({mem_addr, mem_data, mem_wren} !== e) begin bad++; $display("FAIL host_mem got=%h/%h/%b want=%h/%h/%b", mem_addr, mem_data, mem_wren, e.addr, e.data, e.wren); end
      host_req = 0;
      do_reset_and_start();
      finish_init(); finish_shuf();
      tick();
      host_req = 1; host_addr = 8'hFF; host_data = 8'hA5; host_wren = 1;
      tick();
      total++; if ({host_gnt, mem_wren} !== 2'b00) begin bad++; $display("FAIL host_in_dec got=%b/%b want=0/0", host_gnt, mem_wren); end
      host_req = 0;
   endtask

   task automatic test_reset_mid();
      // Still in DEC from the previous scenario.
      dec_wren = 1; dec_addr = 8'h3C; reset = 1; start = 1; start_over = 1;
      tick();
      reset = 0; start = 0; start_over = 0; dec_wren = 0;
      total++; if ({phase, mem_wren} !== {3'd0, 1'b0}) begin bad++; $display("FAIL reset_mid got=%0d/%b want=0/0", phase, mem_wren); end
      total++; if ({init_start, shuf_start, dec_start} !== 3'b000) begin bad++; $display("FAIL reset_mid_starts got=%b want=000", {init_start, shuf_start, dec_start}); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_start_pulse();
      test_full_run();
      test_start_over();
      test_mem_path();
      test_host();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/s_mem_scheduler.md
S_MEM_SCHEDULER -- requirements
Module: s_mem_scheduler

Interface
REQ-001 SHALL have clk, in, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have reset, in, 1: synchronous, active-high reset.
REQ-003 SHALL have start, in, 1: begin full key-schedule/decrypt sequence.
REQ-004 SHALL have start_over, in, 1: abandon current sequence and restart at init phase (new key).
REQ-005 SHALL have init_start / shuf_start / dec_start, out, 1 each: one-cycle phase start pulses.
REQ-006 SHALL have init_done / shuf_done / dec_done, in, 1 each: level done flags from phase engines.
REQ-007 SHALL have init_addr / shuf_addr / dec_addr, in, 8 each: phase-engine S-memory address.
REQ-008 SHALL have init_data / shuf_data / dec_data, in, 8 each: phase-engine write data.
REQ-009 SHALL have init_wren / shuf_wren / dec_wren, in, 1 each: phase-engine write enable.
REQ-010 SHALL have host_req, in, 1; host_addr, in, 8; host_data, in, 8; host_wren, in, 1: host/debug access port.
REQ-011 SHALL have host_gnt, out, 1: host access accepted this cycle.
REQ-012 SHALL have mem_addr, out, 8; mem_data, out, 8; mem_wren, out, 1: registered 256x8 S-memory port.
REQ-013 SHALL have phase, out, 3: state encoding IDLE=0, INIT=1, SHUF=2, DEC=3, DONE=4.
REQ-014 SHALL have busy, out, 1 (high in INIT/SHUF/DEC) and all_done, out, 1 (high in DONE).

Function
REQ-015 SHALL transition IDLE->INIT on start; INIT->SHUF on init_done; SHUF->DEC on shuf_done; DEC->DONE on dec_done; DONE->INIT on start.
REQ-016 SHALL, on start_over in any state, go to INIT next cycle; start_over SHALL take priority over start and every done input.
REQ-017 SHALL pulse the entered phase's *_start for exactly one cycle, the first cycle in the new state (including INIT re-entry via start_over while already in INIT).
REQ-018 SHALL ignore all done inputs during the pulse cycle of REQ-017 (stale level done from the previous run).
REQ-019 SHALL ignore done inputs belonging to non-active phases.
REQ-020 SHALL drive mem_addr/mem_data/mem_wren one cycle after sampling the active phase engine's inputs (latency 1).
REQ-021 SHALL force mem_wren=0 for samples taken during a *_start pulse cycle and during any state change cycle.
REQ-022 SHALL, in IDLE/DONE, drive mem_* from the host port when host_req=1 (latency 1), else mem_wren=0 and mem_addr/mem_data held.
REQ-023 SHALL assert host_gnt registered, one cycle after host_req sampled in IDLE/DONE; host_req in other states SHALL be held off (host_gnt=0, no memory effect).
REQ-024 SHALL never let two sources drive mem_* in the same cycle; addresses wrap naturally in 8 bits, no range checking.

Reset
REQ-025 SHALL, on reset, enter IDLE with phase=0 and busy, all_done, host_gnt, all *_start, mem_addr, mem_data, mem_wren = 0.
REQ-026 SHALL, on reset mid-sequence, issue no start pulse and no write in the following cycle; reset SHALL override start and start_over.

Configuration
REQ-027 SHALL compile the host port only when S_MEM_HOST_PORT_EN is defined.
REQ-028 SHALL, without S_MEM_HOST_PORT_EN, keep host_* ports present but ignored, host_gnt tied 0, mem_wren=0 in IDLE/DONE.

Verification
REQ-029 SHALL cover: reset, start pulse -> init_start high cycle 1 only, phase=1; init_done held high from cycle 1 -> ignored cycle 1, phase=2 cycle 2.
REQ-030 SHALL cover: full run with init_done/shuf_done/dec_done -> phases 1,2,3,4, all_done=1, busy=0; start in DONE -> phase=1, init_start pulse.
REQ-031 SHALL cover: start_over and shuf_done same cycle in SHUF -> phase=1 next cycle, init_start pulse, no shuf->DEC.
REQ-032 SHALL cover: INIT, init_addr=0x05, init_data=0x05, init_wren=1 at cycle t -> mem_addr=0x05, mem_data=0x05, mem_wren=1 at t+1; shuf_wren=1 at t -> no effect.
REQ-033 SHALL cover: macro defined, DONE, host_req=1, host_addr=0xFF, host_wren=1, host_data=0xA5 -> host_gnt=1 and mem write 0xFF<-0xA5 next cycle; same in DEC -> host_gnt=0; macro undefined -> host_gnt=0 always.
REQ-034 SHALL cover: reset asserted in DEC with dec_wren=1 -> next cycle phase=0, mem_wren=0, no start pulses.
